// File: rtl/cam_pkg.sv
// Shared types and default 640x480 timing for the camera test-frame generator.
package cam_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        HRAMP   = 2'd1,
        VRAMP   = 2'd2,
        CHECKER = 2'd3
    } pattern_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SW     = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SW     = 2;
    localparam int DEF_V_BP     = 33;

    // Counters never go below 8 bits so the ramp patterns can use the low byte directly.
    function automatic int cnt_width(input int total);
        int w;
        w = $clog2(total);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/cam_frame_gen_if.sv
// Control and video signal bundle between the frame generator and its user.
interface cam_frame_gen_if;

    logic       EN;
    logic [1:0] MODE;
    logic [7:0] LEVEL;
    logic       H_SYNC;
    logic       V_SYNC;
    logic       DE;
    logic [7:0] pixel;
    logic [7:0] FRAME_CNT;
    logic       FRAME_DONE;

    modport master (
        output EN, MODE, LEVEL,
        input  H_SYNC, V_SYNC, DE, pixel, FRAME_CNT, FRAME_DONE
    );

    modport slave (
        input  EN, MODE, LEVEL,
        output H_SYNC, V_SYNC, DE, pixel, FRAME_CNT, FRAME_DONE
    );

endinterface

// File: rtl/cam_frame_gen_timing.sv
// Raster counters with unregistered sync/DE decode and a frame-boundary strobe.
module vga_timing
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SW     = DEF_H_SW,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SW     = DEF_V_SW,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    output logic [7:0] o_h_lsb,
    output logic [7:0] o_v_lsb,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_de,
    output logic       o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SW);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SW);
    localparam logic [VW-1:0] V_ONE      = VW'(1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    // End-of-line and end-of-frame position flags.
    always_comb begin
        w_h_last = (r_h_cnt == H_LAST);
        w_v_last = (r_v_cnt == V_LAST);
    end

    // Raster position; held at the origin whenever the generator is parked.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : (r_v_cnt + V_ONE);
        end else begin
            r_h_cnt <= r_h_cnt + H_ONE;
        end
    end

    // Decode of the current position; the parent registers these.
    always_comb begin
        o_h_lsb     = r_h_cnt[7:0];
        o_v_lsb     = r_v_cnt[7:0];
        o_hsync_n   = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
        o_vsync_n   = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
        o_de        = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        o_frame_end = i_run && w_h_last && w_v_last;
    end

endmodule

// File: rtl/cam_frame_gen.sv
// Test-pattern video source: raster timing plus pattern, enable and frame counting.
module cam_frame_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SW     = DEF_H_SW,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SW     = DEF_V_SW,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic           VGA_CLK,
    input  logic           RST,
    cam_frame_gen_if.slave cam_bus
);

    logic [7:0] w_h_lsb;
    logic [7:0] w_v_lsb;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic       w_de;
    logic       w_frame_end;
    logic       w_sample;
    logic [7:0] w_pattern;

    logic       r_run;
    pattern_e   r_mode;
    logic [7:0] r_level;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [7:0] r_pixel;
    logic [7:0] r_frame_cnt;
    logic       r_frame_done;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SW     (H_SW),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SW     (V_SW),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (VGA_CLK),
        .i_rst       (RST),
        .i_run       (r_run),
        .o_h_lsb     (w_h_lsb),
        .o_v_lsb     (w_v_lsb),
        .o_hsync_n   (w_hsync_n),
        .o_vsync_n   (w_vsync_n),
        .o_de        (w_de),
        .o_frame_end (w_frame_end)
    );

    // Settings are taken every clock while parked, otherwise only on the last clock of a frame.
    assign w_sample = ~r_run | w_frame_end;

    // Pattern value for the current position under the latched mode.
    always_comb begin
        w_pattern = 8'h00;
        case (r_mode)
            SOLID:   w_pattern = r_level;
            HRAMP:   w_pattern = w_h_lsb;
            VRAMP:   w_pattern = w_v_lsb;
            CHECKER: w_pattern = (w_h_lsb[3] ^ w_v_lsb[3]) ? 8'hFF : 8'h00;
            default: w_pattern = 8'h00;
        endcase
    end

    // Run enable and pattern settings for the frame about to start.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            r_run   <= 1'b0;
            r_mode  <= SOLID;
            r_level <= 8'h00;
        end else if (w_sample) begin
            r_run   <= cam_bus.EN;
            r_mode  <= pattern_e'(cam_bus.MODE);
            r_level <= cam_bus.LEVEL;
        end
    end

    // Output stage: one clock behind the counters, idle levels while parked.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_de         <= 1'b0;
            r_pixel      <= 8'h00;
            r_frame_cnt  <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_hsync      <= r_run ? w_hsync_n : 1'b1;
            r_vsync      <= r_run ? w_vsync_n : 1'b1;
            r_de         <= r_run & w_de;
            r_pixel      <= (r_run && w_de) ? w_pattern : 8'h00;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign cam_bus.H_SYNC     = r_hsync;
    assign cam_bus.V_SYNC     = r_vsync;
    assign cam_bus.DE         = r_de;
    assign cam_bus.pixel      = r_pixel;
    assign cam_bus.FRAME_CNT  = r_frame_cnt;
    assign cam_bus.FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_cam_frame_gen.sv
// Self-checking bench for cam_frame_gen on a 12x7 raster, with a linear-position reference model.
module tb_cam_frame_gen;
    import cam_pkg::*;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int FLEN = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cam_frame_gen_if bus_if ();

    cam_frame_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SW (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SW (VS), .V_BP (VB)
    ) dut (
        .VGA_CLK (clk),
        .RST     (rst),
        .cam_bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: running flag plus linear position within the frame
    bit         m_run;
    int         m_pos;
    logic [1:0] m_mode;
    logic [7:0] m_level;
    int         m_fcnt;

    int s_de, s_sum, s_vs_low, s_vs_cur, s_vs_max, s_hs_low, s_fd;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] level;
        int         exp_de;
        int         exp_sum;
        int         exp_vs;
        int         exp_hs;
        int         exp_fd;
        int         exp_fcnt;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_pos   = 0;
        m_mode  = 2'd0;
        m_level = 8'h00;
        m_fcnt  = 0;
    endtask

    task automatic clear_stats();
        s_de = 0; s_sum = 0; s_vs_low = 0; s_vs_cur = 0; s_vs_max = 0; s_hs_low = 0; s_fd = 0;
    endtask

    // One clock: predict the outputs from the model, advance it, then compare after the edge.
    task automatic step();
        int col, line;
        logic e_hs, e_vs, e_de, e_fd;
        logic [7:0] e_pix;
        logic [19:0] exp_v, act_v;
        @(posedge clk);
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_pix = 8'h00; e_fd = 1'b0;
        if (m_run) begin
            col  = m_pos % HT;
            line = m_pos / HT;
            e_hs = !(col >= HA + HF && col < HA + HF + HS);
            e_vs = !(line >= VA + VF && line < VA + VF + VS);
            e_de = (col < HA) && (line < VA);
            if (e_de) begin
                case (m_mode)
                    2'd0:    e_pix = m_level;
                    2'd1:    e_pix = 8'(col % 256);
                    2'd2:    e_pix = 8'(line % 256);
                    default: e_pix = (((col / 8) % 2) != ((line / 8) % 2)) ? 8'hFF : 8'h00;
                endcase
            end
            e_fd = (m_pos == FLEN - 1);
            if (e_fd) m_fcnt = (m_fcnt + 1) % 256;
        end
        if (!m_run || m_pos == FLEN - 1) begin
            m_run   = bus_if.EN;
            m_mode  = bus_if.MODE;
            m_level = bus_if.LEVEL;
            m_pos   = 0;
        end else begin
            m_pos++;
        end
        #1;
        exp_v = {e_hs, e_vs, e_de, e_pix, 8'(m_fcnt), e_fd};
        act_v = {bus_if.H_SYNC, bus_if.V_SYNC, bus_if.DE, bus_if.pixel, bus_if.FRAME_CNT, bus_if.FRAME_DONE};
        check("outputs{hs,vs,de,pix,cnt,done}", 32'(act_v), 32'(exp_v));
        if (bus_if.DE) s_de++;
        s_sum += int'(bus_if.pixel);
        if (!bus_if.V_SYNC) begin
            s_vs_low++;
            s_vs_cur++;
            if (s_vs_cur > s_vs_max) s_vs_max = s_vs_cur;
        end else begin
            s_vs_cur = 0;
        end
        if (!bus_if.H_SYNC) s_hs_low++;
        if (bus_if.FRAME_DONE) s_fd++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Assert reset between edges and expect reset values before any clock arrives.
    task automatic async_reset_check(input string name);
        rst = 1'b1;
        model_reset();
        #1;
        check(name, 32'({bus_if.H_SYNC, bus_if.V_SYNC, bus_if.DE, bus_if.pixel, bus_if.FRAME_CNT, bus_if.FRAME_DONE}),
              32'({1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_to_pos(input int pos);
        for (int i = 0; i < 2 * FLEN && !(m_run && m_pos == pos); i++) step();
    endtask

    int nfd;

    initial begin
        tbl[0] = '{1'b1, 2'd0, 8'd200, 32, 6400, 12, 14, 1, 1};
        tbl[1] = '{1'b1, 2'd1, 8'h55,  32, 112,  12, 14, 1, 1};
        tbl[2] = '{1'b1, 2'd2, 8'h55,  32, 48,   12, 14, 1, 1};
        tbl[3] = '{1'b1, 2'd3, 8'h55,  32, 0,    12, 14, 1, 1};
        tbl[4] = '{1'b0, 2'd0, 8'd200, 0,  0,    0,  0,  0, 0};

        bus_if.EN = 1'b0; bus_if.MODE = 2'd0; bus_if.LEVEL = 8'h00;
        model_reset();
        clear_stats();
        #1 rst = 1'b1;
        #1;
        check("reset_values", 32'({bus_if.H_SYNC, bus_if.V_SYNC, bus_if.DE, bus_if.pixel, bus_if.FRAME_CNT, bus_if.FRAME_DONE}),
              32'({1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));

        // one frame per pattern from a fresh reset
        for (int t = 0; t < 5; t++) begin
            bus_if.EN = tbl[t].en; bus_if.MODE = tbl[t].mode; bus_if.LEVEL = tbl[t].level;
            do_reset();
            clear_stats();
            repeat (FLEN + 1) step();
            check("tbl_de_count",  32'(s_de),              32'(tbl[t].exp_de));
            check("tbl_pixel_sum", 32'(s_sum),             32'(tbl[t].exp_sum));
            check("tbl_vs_low",    32'(s_vs_low),          32'(tbl[t].exp_vs));
            check("tbl_vs_run",    32'(s_vs_max),          32'(tbl[t].exp_vs));
            check("tbl_hs_low",    32'(s_hs_low),          32'(tbl[t].exp_hs));
            check("tbl_done",      32'(s_fd),              32'(tbl[t].exp_fd));
            check("tbl_frame_cnt", 32'(bus_if.FRAME_CNT),  32'(tbl[t].exp_fcnt));
        end

        // mode change at line 2 only takes effect on the next frame
        bus_if.EN = 1'b1; bus_if.MODE = 2'd0; bus_if.LEVEL = 8'd77;
        do_reset();
        step();
        run_to_pos(24);
        bus_if.MODE = 2'd3;
        clear_stats();
        repeat (FLEN - 24) step();
        check("mode_hold_sum", 32'(s_sum), 32'(16 * 77));
        check("mode_hold_done", 32'(s_fd), 32'd1);
        clear_stats();
        repeat (FLEN) step();
        check("checker_sum", 32'(s_sum), 32'd0);
        check("checker_de", 32'(s_de), 32'd32);

        // enable dropped mid-frame: frame completes, then idles; re-raise restarts at origin
        bus_if.MODE = 2'd0; bus_if.LEVEL = 8'd9;
        do_reset();
        step();
        run_to_pos(30);
        bus_if.EN = 1'b0;
        clear_stats();
        repeat (FLEN - 30) step();
        check("en_drop_done", 32'(s_fd), 32'd1);
        check("en_drop_de", 32'(s_de), 32'd10);
        clear_stats();
        repeat (20) step();
        check("idle_de", 32'(s_de), 32'd0);
        check("idle_hs", 32'(s_hs_low), 32'd0);
        check("idle_vs", 32'(s_vs_low), 32'd0);
        bus_if.EN = 1'b1;
        step();
        step();
        check("restart_de", 32'(bus_if.DE), 32'd1);
        check("restart_pix", 32'(bus_if.pixel), 32'd9);

        // reset at h=5, v=2 of the third frame
        bus_if.MODE = 2'd1;
        do_reset();
        step();
        repeat (2 * FLEN) step();
        check("pre_rst_cnt", 32'(bus_if.FRAME_CNT), 32'd2);
        run_to_pos(29);
        async_reset_check("midframe_rst");
        clear_stats();
        repeat (FLEN) step();
        check("no_done_after_rst", 32'(s_fd), 32'd0);
        step();
        check("first_done_after_rst", 32'(bus_if.FRAME_DONE), 32'd1);

        // randomized enable / mode / level traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus_if.EN    = ($urandom_range(0, 9) != 0);
            bus_if.MODE  = 2'($urandom_range(0, 3));
            bus_if.LEVEL = 8'($urandom_range(0, 255));
            if (i == 1500) async_reset_check("random_rst");
            step();
        end

        // frame counter wrap over 257 frames
        bus_if.EN = 1'b1;
        do_reset();
        nfd = 0;
        for (int i = 0; i < 258 * FLEN && nfd < 257; i++) begin
            bus_if.MODE  = 2'($urandom_range(0, 3));
            bus_if.LEVEL = 8'($urandom_range(0, 255));
            step();
            if (bus_if.FRAME_DONE) begin
                nfd++;
                if (nfd == 255) check("cnt_255", 32'(bus_if.FRAME_CNT), 32'd255);
                if (nfd == 256) check("cnt_wrap0", 32'(bus_if.FRAME_CNT), 32'd0);
                if (nfd == 257) check("cnt_wrap1", 32'(bus_if.FRAME_CNT), 32'd1);
            end
        end
        check("frames_seen", 32'(nfd), 32'd257);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
